// File: rtl/serial_word_feeder.sv
// serial_word_feeder: accepts parallel words over valid/ready and shifts each
// one LSB-first onto SI, pulsing shift_control once per bit. A one-word hold
// buffer lets the producer queue the next word while the current one shifts.
// Optional build macro: SERIAL_FEEDER_PARITY_EN appends an even-parity bit
// (XOR of the data bits) after the data bits of every word.
module serial_word_feeder #(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             SI,
  output logic             shift_control,
  output logic             busy,
  output logic             word_done
);

`ifdef SERIAL_FEEDER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(NBITS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [NBITS-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  // Set for one cycle after the held word moves into the shifter; the buffer
  // is released (and data_ready rises) on the following edge.
  logic             hold_taken_q, hold_taken_d;
  logic             word_done_q, word_done_d;

  logic accept;
  logic hold_valid;
  logic boundary;
  logic bypass;

  // Build the on-wire frame for one word: data bits, plus parity when enabled.
  function automatic logic [NBITS-1:0] frame(input logic [WIDTH-1:0] w);
`ifdef SERIAL_FEEDER_PARITY_EN
    frame = {^w, w};
`else
    frame = w;
`endif
  endfunction

  assign data_ready    = !hold_full_q && !clear;
  assign accept        = data_valid && data_ready;
  assign hold_valid    = hold_full_q && !hold_taken_q;
  assign shift_control = (state_q == SHIFT);
  assign SI            = shift_control & shreg_q[0];
  assign busy          = (state_q != IDLE);
  assign word_done     = word_done_q;

  // Next-state logic: FSM sequencing, shifting, gap timing and hold buffer.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    hold_taken_d = 1'b0;
    word_done_d  = 1'b0;
    boundary     = 1'b0;
    bypass       = 1'b0;

    if (hold_taken_q) begin
      hold_full_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d   = frame(data_in);
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d   = shreg_q >> 1;
        bit_cnt_d = bit_cnt_q + CW'(1);
        if (bit_cnt_q == LAST_BIT) begin
          word_done_d = 1'b1;
          bit_cnt_d   = '0;
          if (GAP_CYCLES > 0) begin
            state_d   = GAP;
            gap_cnt_d = '0;
          end else begin
            boundary = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          boundary = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // End of a word (after any gap): continue with the held word, or with a
    // word offered on this very edge, otherwise fall back to IDLE.
    if (boundary) begin
      bit_cnt_d = '0;
      if (hold_valid) begin
        shreg_d      = frame(hold_q);
        hold_taken_d = 1'b1;
        state_d      = SHIFT;
      end else if (accept) begin
        shreg_d = frame(data_in);
        bypass  = 1'b1;
        state_d = SHIFT;
      end else begin
        state_d = IDLE;
      end
    end

    // A word accepted while busy waits in the hold buffer, unless it went
    // straight into the shifter at a word boundary.
    if (accept && (state_q != IDLE) && !bypass) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end
  end

  // State registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      hold_taken_q <= 1'b0;
      word_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      hold_taken_q <= hold_taken_d;
      word_done_q  <= word_done_d;
    end
  end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Testbench for serial_word_feeder: two instances (GAP_CYCLES=1 and 0) driven
// by directed and random producers, checked every cycle against a schedule
// model that places each accepted word's bits, done pulse, busy window and
// hold-buffer occupancy on a cycle timeline.
module tb_serial_word_feeder;
  localparam int W = 4;
`ifdef SERIAL_FEEDER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif
  localparam int N = 4096;

  logic         clk;
  logic         clear;
  logic [W-1:0] din [2];
  logic         dv  [2];
  logic rdy_a, si_a, sc_a, busy_a, wd_a;
  logic rdy_b, si_b, sc_b, busy_b, wd_b;

  int tests = 0;
  int fails = 0;
  int cyc;

  // Expected per-cycle timeline, index [dut][cycle after edge number]
  bit e_sc   [2][N];
  bit e_si   [2][N];
  bit e_wd   [2][N];
  bit e_busy [2][N];
  bit e_blk  [2][N];
  int free_c [2];
  bit acc    [2];

  serial_word_feeder #(.WIDTH(W), .GAP_CYCLES(1)) dut_g1 (
    .clk(clk), .clear(clear), .data_in(din[0]), .data_valid(dv[0]),
    .data_ready(rdy_a), .SI(si_a), .shift_control(sc_a), .busy(busy_a),
    .word_done(wd_a)
  );

  serial_word_feeder #(.WIDTH(W), .GAP_CYCLES(0)) dut_g0 (
    .clk(clk), .clear(clear), .data_in(din[1]), .data_valid(dv[1]),
    .data_ready(rdy_b), .SI(si_b), .shift_control(sc_b), .busy(busy_b),
    .word_done(wd_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int gapv(input int g);
    return (g == 0) ? 1 : 0;
  endfunction

  // Bits sent on the wire for one word, LSB first; parity = odd count of ones.
  function automatic logic [NB-1:0] wire_bits(input logic [W-1:0] d);
    logic [NB-1:0] b;
    b = '0;
    for (int i = 0; i < W; i++) b[i] = d[i];
`ifdef SERIAL_FEEDER_PARITY_EN
    b[W] = ($countones(d) % 2) == 1;
`endif
    return b;
  endfunction

  task automatic chk(input string tag, input int g, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dut%0d cycle %0d: got %b want %b", tag, g, cyc, obs, exp);
    end
  endtask

  // Place a word accepted at edge e onto the timeline of dut g.
  task automatic schedule(input int g, input int e, input logic [W-1:0] d);
    logic [NB-1:0] b;
    int s;
    b = wire_bits(d);
    s = (e > free_c[g]) ? e : free_c[g];
    for (int i = 0; i < NB; i++) begin
      e_sc[g][s+i] = 1'b1;
      e_si[g][s+i] = b[i];
    end
    e_wd[g][s+NB] = 1'b1;
    for (int i = s; i < s + NB + gapv(g); i++) e_busy[g][i] = 1'b1;
    if (s > e) begin
      for (int i = e; i <= s; i++) e_blk[g][i] = 1'b1;
    end
    free_c[g] = s + NB + gapv(g);
    $display("[TB] dut%0d accepted %b at edge %0d, first bit in cycle %0d", g, d, e, s);
  endtask

  // Apply the coming edge to the model using the inputs of the current cycle.
  task automatic model_edge();
    for (int g = 0; g < 2; g++) begin
      acc[g] = 1'b0;
      if (clear) begin
        for (int i = cyc + 1; i < N; i++) begin
          e_sc[g][i] = 1'b0; e_si[g][i] = 1'b0; e_wd[g][i] = 1'b0;
          e_busy[g][i] = 1'b0; e_blk[g][i] = 1'b0;
        end
        free_c[g] = 0;
      end else if (dv[g] && !e_blk[g][cyc]) begin
        schedule(g, cyc + 1, din[g]);
        acc[g] = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    logic o_sc, o_si, o_wd, o_busy, o_rdy;
    for (int g = 0; g < 2; g++) begin
      o_sc   = (g == 0) ? sc_a   : sc_b;
      o_si   = (g == 0) ? si_a   : si_b;
      o_wd   = (g == 0) ? wd_a   : wd_b;
      o_busy = (g == 0) ? busy_a : busy_b;
      o_rdy  = (g == 0) ? rdy_a  : rdy_b;
      chk("shift_control", g, o_sc, e_sc[g][cyc]);
      chk("SI", g, o_si, e_si[g][cyc]);
      chk("word_done", g, o_wd, e_wd[g][cyc]);
      chk("busy", g, o_busy, e_busy[g][cyc]);
      chk("data_ready", g, o_rdy, !clear && !e_blk[g][cyc]);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Offer a word to each dut and hold it until that dut accepts it.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    bit done [2];
    int n;
    din[0] = a; din[1] = b;
    dv[0] = 1'b1; dv[1] = 1'b1;
    done[0] = 1'b0; done[1] = 1'b0;
    n = 0;
    while (!(done[0] && done[1]) && n < 40) begin
      step();
      for (int g = 0; g < 2; g++) begin
        if (acc[g]) begin
          done[g] = 1'b1;
          dv[g] = 1'b0;
        end
      end
      n++;
    end
    chk("accept_timeout", 0, done[0], 1'b1);
    chk("accept_timeout", 1, done[1], 1'b1);
    dv[0] = 1'b0; dv[1] = 1'b0;
  endtask

  initial begin
    cyc = 0;
    clear = 1'b1;
    dv[0] = 1'b0; dv[1] = 1'b0;
    din[0] = '0; din[1] = '0;
    free_c[0] = 0; free_c[1] = 0;
    @(negedge clk);

    // Reset held for two edges, then released: ready must rise at once
    step();
    step();
    clear = 1'b0;
    #1;
    check_all();

    // Single word
    send(4'b1011, 4'b1011);
    idle(8);

    // Back-to-back: second word queued in the hold buffer
    send(4'b1010, 4'b1010);
    send(4'b0101, 4'b0101);
    idle(14);

    // Three words in quick succession
    send(4'b1100, 4'b0110);
    send(4'b1001, 4'b0011);
    send(4'b0001, 4'b1110);
    idle(20);

    // Clear in the middle of a word with another word held
    send(4'b1111, 4'b1111);
    send(4'b0011, 4'b0011);
    clear = 1'b1;
    step();
    clear = 1'b0;
    idle(12);

    // Word whose parity bit is 1 when parity is built in
    send(4'b0111, 4'b0111);
    idle(10);

    // Random producers, blocked offers with changing data, sporadic clears
    for (int k = 0; k < 900; k++) begin
      clear = ($urandom_range(0, 99) < 2);
      for (int g = 0; g < 2; g++) begin
        if (!dv[g]) begin
          if ($urandom_range(0, 2) == 0) begin
            dv[g] = 1'b1;
            din[g] = 4'($urandom);
          end
        end else if (e_blk[g][cyc]) begin
          din[g] = 4'($urandom);
        end
      end
      step();
      for (int g = 0; g < 2; g++) begin
        if (acc[g]) begin
          if ($urandom_range(0, 1) == 0) dv[g] = 1'b0;
          else din[g] = 4'($urandom);
        end
      end
    end

    clear = 1'b0;
    dv[0] = 1'b0; dv[1] = 1'b0;
    idle(24);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_word_feeder.md
Name: serial_word_feeder

Overview:
- Upstream feeder for the 4-bit serial-in shift register.
- Accepts parallel words over a valid/ready handshake and serializes each one LSB-first onto SI.
- Drives shift_control high for exactly one cycle per transmitted bit.
- A one-word hold buffer lets the producer queue the next word while the current word is shifting.

Parameters:
- WIDTH, 4: data bits per word.
- GAP_CYCLES, 1: idle cycles (shift_control=0) inserted after each word; 0 gives back-to-back words.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- clear, input, 1: synchronous, active-high reset.
- data_in, input, WIDTH: parallel word from producer.
- data_valid, input, 1: producer offers data_in this cycle.
- data_ready, output, 1: feeder can accept a word; transfer occurs on an edge where data_valid and data_ready are both 1.
- SI, output, 1: serial data to the downstream shift register.
- shift_control, output, 1: downstream shift enable; 1 exactly while a bit is presented on SI.
- busy, output, 1: FSM not in IDLE.
- word_done, output, 1: one-cycle pulse after the last bit of a word.

Behaviour:
- Reset: while clear=1 at an edge:
  - state becomes IDLE and the hold buffer is emptied;
  - shift register, bit counter and gap counter go to 0;
  - SI=0, shift_control=0, busy=0, word_done=0.
- data_ready is forced to 0 combinationally while clear=1, and is 1 in the first cycle after clear deasserts.
- FSM states are IDLE, SHIFT and GAP.
- IDLE:
  - Hold buffer is always empty in IDLE.
  - An accept at edge k loads data_in directly into the shift register, clears the bit counter, and moves to SHIFT.
- SHIFT:
  - shift_control=1 and SI = current LSB of the shift register.
  - Each edge shifts right and increments the bit counter.
  - In cycles k+1..k+WIDTH, SI carries bit0..bit(WIDTH-1).
  - At the edge ending the last bit: word_done is registered high for exactly one cycle. Then:
    - if GAP_CYCLES>0, go to GAP;
    - otherwise, if the hold buffer is full, move the hold word into the shift register and stay in SHIFT (no bubble);
    - otherwise, go to IDLE.
- GAP:
  - shift_control=0, SI=0, busy=1.
  - Lasts exactly GAP_CYCLES cycles.
  - On exit, if the hold buffer is full, its word moves into the shift register and the FSM enters SHIFT; otherwise it enters IDLE.
- Hold buffer:
  - An accept while busy=1 stores data_in in the hold buffer.
  - data_ready = !hold_full && !clear, so at most one queued word exists.
  - A hold-to-shifter transfer and a new accept never coincide, because ready is low while the buffer is full.
  - data_ready rises the cycle after the transfer.
- SI is 0 whenever shift_control=0. There is no X on SI after reset.
- Blocked offers: data_valid=1 while data_ready=0 is ignored. The producer must hold data_in stable until it is accepted.
- clear mid-word: the current word is aborted and the held word discarded. Outputs take their reset values the cycle after the clear edge, and no word_done pulse is issued.
- Throughput:
  - WIDTH bits every WIDTH+GAP_CYCLES cycles when the producer keeps data_valid high.
  - Latency from accept edge to first bit on SI is 1 cycle.

Optional Feature:
- Macro: SERIAL_FEEDER_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one extra bit is shifted out: even parity, the XOR of all data bits of that word.
  - shift_control stays high for WIDTH+1 cycles.
  - word_done follows the parity bit.
  - The bit counter is sized for WIDTH+1.
- Undefined:
  - No parity logic is present.
  - Each word occupies exactly WIDTH shift cycles.

Test Plan (WIDTH=4, GAP_CYCLES=1 unless noted):
- Reset: clear=1 for 2 cycles, then 0 → SI=0, shift_control=0, busy=0, word_done=0; data_ready=0 during clear and 1 afterwards.
- Single word: data_in=4'b1011 accepted at edge k → cycles k+1..k+4 show shift_control=1 with SI=1,1,0,1. Cycle k+5 shows word_done=1, shift_control=0 (gap). busy=0 from cycle k+6.
- Back-to-back: 4'b1010 accepted at k, then 4'b0101 offered from k+1:
  - second word accepted at edge k+1, and data_ready=0 from cycle k+2;
  - first word shifts SI=0,1,0,1, followed by a 1-cycle gap;
  - second word shifts SI=1,0,1,0 in cycles k+6..k+9;
  - data_ready returns to 1 in cycle k+7.
- GAP_CYCLES=0 with two queued words → shift_control stays high for 8 consecutive cycles, with word_done pulses after bit 4 and after bit 8.
- Clear mid-shift: clear=1 after 2 bits of 4'b1111 while 4'b0011 is held → the next cycle shows shift_control=0, SI=0, busy=0, no word_done, and the held word is never transmitted.
- Parity build: data_in=4'b0111 → SI=1,1,1,0,1 over 5 shift_control cycles, then word_done. A blocked offer (data_valid=1, data_ready=0, data_in changing) is never transmitted.
